load_store_unit_v1: RTL and testbench

Load/store unit directly upstream of the memory unit. It accepts one byte-addressed load/store request at a time from the core execute stage. It converts each request into word-wide accesses on the memory unit's 10-bit word-address port, including read-modify-write for SB/SH. Loaded data returns to the core with byte/half extraction and sign/zero extension; misaligned, illegal or out-of-range requests are rejected.

---
 rtl/load_store_unit_v1_if.sv | 27 ++
 rtl/load_store_unit_v1.sv | 134 +++++++++++++
 tb/tb_load_store_unit_v1.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_v1_if.sv
// Core request/response channel plus the word-wide memory port of the load/store unit.
// The slave side is the LSU itself; the master side is its environment (core and memory).
interface load_store_unit_v1_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/load_store_unit_v1.sv
// Byte-addressed load/store unit in front of a word-addressed memory: one request at a time,
// sub-word stores done as read-modify-write, loads returned with byte/half extension.
module load_store_unit_v1 #(
   parameter int         READ_LATENCY = 1,
   parameter logic [9:0] MMIO_BASE    = 10'h3E8
) (
   input logic clk,
   input logic rst,
   load_store_unit_v1_if.slave bus
);

   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

   state_t      state, state_next;
   logic [9:0]  word_addr_q;
   logic [1:0]  lane_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] data_q;
   logic [2:0]  cnt_q;

   logic        accept;
   logic        req_err;
   logic        is_mmio;
   logic [31:0] merged;
   logic [31:0] loaded;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign accept  = (state == IDLE) && bus.req_valid;
   assign is_mmio = (bus.req_addr[11:2] >= MMIO_BASE);

   // Reject anything that cannot map onto a single legal word access; sub-word stores
   // would need a read of the MMIO window, which has side effects, so they are refused there.
   always_comb begin
      req_err = (bus.req_addr[31:12] != 20'd0);
      if (bus.req_we) begin
         case (bus.req_funct3)
            3'b000:  req_err = req_err | is_mmio;
            3'b001:  req_err = req_err | bus.req_addr[0] | is_mmio;
            3'b010:  req_err = req_err | (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
         endcase
      end else begin
         case (bus.req_funct3)
            3'b000, 3'b100: req_err = req_err;
            3'b001, 3'b101: req_err = req_err | bus.req_addr[0];
            3'b010:         req_err = req_err | (bus.req_addr[1:0] != 2'b00);
            default:        req_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                                     state_next = RESP;
               else if (bus.req_we && bus.req_funct3 == 3'b010) state_next = WRITE;
               else                                             state_next = READ;
            end
         end
         READ:    if (cnt_q == 3'(READ_LATENCY - 1)) state_next = CAPTURE;
         CAPTURE: state_next = we_q ? WRITE : RESP;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane selection is little-endian: lane 0 is bits [7:0] of the word.
   assign byte_v = bus.mem_rdata[{lane_q, 3'b000} +: 8];
   assign half_v = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      merged = bus.mem_rdata;
      case (funct3_q[1:0])
         2'b00:   merged[{lane_q, 3'b000} +: 8]     = data_q[7:0];
         2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
         default: merged = bus.mem_rdata;
      endcase
   end

   always_comb begin
      case (funct3_q)
         3'b000:  loaded = {{24{byte_v[7]}}, byte_v};
         3'b100:  loaded = {24'd0, byte_v};
         3'b001:  loaded = {{16{half_v[15]}}, half_v};
         3'b101:  loaded = {16'd0, half_v};
         default: loaded = bus.mem_rdata;
      endcase
   end

   // data_q holds store data from accept, then either the merged word or the load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_addr_q <= 10'd0;
         lane_q      <= 2'd0;
         funct3_q    <= 3'd0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         data_q      <= 32'd0;
         cnt_q       <= 3'd0;
      end else begin
         if (accept) begin
            word_addr_q <= bus.req_addr[11:2];
            lane_q      <= bus.req_addr[1:0];
            funct3_q    <= bus.req_funct3;
            we_q        <= bus.req_we;
            err_q       <= req_err;
            data_q      <= bus.req_wdata;
            cnt_q       <= 3'd0;
         end
         if (state == READ)    cnt_q  <= cnt_q + 3'd1;
         if (state == CAPTURE) data_q <= we_q ? merged : loaded;
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.mem_addr   = (state == IDLE) ? 10'd0 : word_addr_q;
   assign bus.mem_we     = (state == WRITE);
   assign bus.mem_wdata  = (state == WRITE) ? data_q : 32'd0;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_err   = (state == RESP) && err_q;
   assign bus.resp_rdata = (state == RESP && !err_q && !we_q) ? data_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit_v1.sv
// Bench for load_store_unit_v1: two instances (read latency 1 and 3) on behavioural memories,
// responses and memory writes checked against a scoreboard of expected values.
`timescale 1ns/1ps
module tb_load_store_unit_v1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_v1_if bus1 ();
   load_store_unit_v1_if bus3 ();

   load_store_unit_v1 #(.READ_LATENCY(1), .MMIO_BASE(10'h3E8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   load_store_unit_v1 #(.READ_LATENCY(3), .MMIO_BASE(10'h3E8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   logic [1:0]        req_valid = 2'b00;
   logic [1:0]        req_we    = 2'b00;
   logic [1:0][2:0]   req_funct3 = '0;
   logic [1:0][31:0]  req_addr   = '0;
   logic [1:0][31:0]  req_wdata  = '0;
   wire  [1:0]        req_ready, resp_valid, resp_err, mem_we;
   wire  [1:0][31:0]  resp_rdata, mem_wdata;
   wire  [1:0][9:0]   mem_addr;

   assign bus1.req_valid  = req_valid[0];
   assign bus1.req_we     = req_we[0];
   assign bus1.req_funct3 = req_funct3[0];
   assign bus1.req_addr   = req_addr[0];
   assign bus1.req_wdata  = req_wdata[0];
   assign bus3.req_valid  = req_valid[1];
   assign bus3.req_we     = req_we[1];
   assign bus3.req_funct3 = req_funct3[1];
   assign bus3.req_addr   = req_addr[1];
   assign bus3.req_wdata  = req_wdata[1];

   assign req_ready  = {bus3.req_ready,  bus1.req_ready};
   assign resp_valid = {bus3.resp_valid, bus1.resp_valid};
   assign resp_err   = {bus3.resp_err,   bus1.resp_err};
   assign mem_we     = {bus3.mem_we,     bus1.mem_we};
   assign resp_rdata = {bus3.resp_rdata, bus1.resp_rdata};
   assign mem_wdata  = {bus3.mem_wdata,  bus1.mem_wdata};
   assign mem_addr   = {bus3.mem_addr,   bus1.mem_addr};

   // Behavioural memories whose read data lags mem_addr by exactly the instance latency.
   logic [31:0] mem1 [1024];
   logic [31:0] mem3 [1024];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [3];

   always @(posedge clk) begin
      if (bus1.mem_we === 1'b1) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      if (bus3.mem_we === 1'b1) mem3[bus3.mem_addr] <= bus3.mem_wdata;
      pipe1    <= mem1[bus1.mem_addr];
      pipe3[0] <= mem3[bus3.mem_addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign bus1.mem_rdata = pipe1;
   assign bus3.mem_rdata = pipe3[2];

   typedef struct {logic err; logic [31:0] rdata;} resp_t;
   typedef struct {logic [9:0] addr; logic [31:0] data;} wr_t;
   resp_t resp_q[$];
   wr_t   wr_q[$];
   resp_t exp_resp;
   wr_t   exp_wr;

   int checks = 0;
   int errors = 0;

   // Scoreboard: every response pulse and every memory write must match the next expectation.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (resp_valid[u] === 1'b1) begin
            checks++;
            if (resp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL resp_unexpected unit %0d: got err=%0b rdata=%h, expected no response", u, resp_err[u], resp_rdata[u]);
            end else begin
               exp_resp = resp_q.pop_front();
               if (resp_err[u] !== exp_resp.err || resp_rdata[u] !== exp_resp.rdata) begin
                  errors++;
                  $display("[TB] FAIL resp_data unit %0d: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                           u, resp_err[u], resp_rdata[u], exp_resp.err, exp_resp.rdata);
               end
            end
         end
         if (mem_we[u] === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL write_unexpected unit %0d: got addr=%h data=%h, expected no write", u, mem_addr[u], mem_wdata[u]);
            end else begin
               exp_wr = wr_q.pop_front();
               if (mem_addr[u] !== exp_wr.addr || mem_wdata[u] !== exp_wr.data) begin
                  errors++;
                  $display("[TB] FAIL write_data unit %0d: got addr=%h data=%h, expected addr=%h data=%h",
                           u, mem_addr[u], mem_wdata[u], exp_wr.addr, exp_wr.data);
               end
            end
         end
      end
   end

   // Drives one request, returns response cycle (relative to accept cycle T), write cycle/count,
   // whether mem_addr held the word address and whether req_ready behaved (1 at accept, 0 while busy).
   task automatic applyStimulus(input int u, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int resp_cyc, output int we_cyc, output int we_cnt,
                                output bit stable, output bit ready_ok);
      logic [9:0] wa;
      wa = addr[11:2];
      @(negedge clk);
      req_valid[u] = 1'b1; req_we[u] = we; req_funct3[u] = f3; req_addr[u] = addr; req_wdata[u] = wdata;
      ready_ok = (req_ready[u] === 1'b1);
      @(posedge clk);
      #1 req_valid[u] = 1'b0;
      resp_cyc = -1; we_cyc = 0; we_cnt = 0; stable = 1'b1;
      for (int n = 1; n <= 30 && resp_cyc < 0; n++) begin
         @(negedge clk);
         if (mem_addr[u] !== wa) stable = 1'b0;
         if (req_ready[u] !== 1'b0) ready_ok = 1'b0;
         if (mem_we[u] === 1'b1) begin we_cnt++; we_cyc = n; end
         if (resp_valid[u] === 1'b1) resp_cyc = n;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b11 || resp_valid !== 2'b00 || resp_err !== 2'b00 || mem_we !== 2'b00 ||
          resp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got ready=%b rv=%b err=%b we=%b rdata=%h addr=%h wdata=%h, expected ready=11 rest 0",
                  req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_addr, mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [5] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001};
      logic [31:0] adrs [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps [5] = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'h00008899, 32'hFFFFAABB};
      int rc, wc, wn; bit st, ro;
      for (int i = 0; i < 5; i++) begin
         resp_q.push_back('{1'b0, exps[i]});
         applyStimulus(0, 1'b0, f3s[i], adrs[i], 32'h0, rc, wc, wn, st, ro);
         checks++;
         if (rc !== 3 || wn !== 0 || !st || !ro) begin
            errors++;
            $display("[TB] FAIL load_timing %0d: got resp T+%0d writes %0d stable %0b ready %0b, expected T+3 0 1 1", i, rc, wn, st, ro);
         end
      end
   endtask

   task automatic test_sub_word_stores();
      int rc, wc, wn; bit st, ro;
      mem1[10'h008] = 32'h11223344;
      wr_q.push_back('{10'h008, 32'h1122CC44});
      resp_q.push_back('{1'b0, 32'h0});
      applyStimulus(0, 1'b1, 3'b000, 32'h21, 32'h000000CC, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 4 || wc !== 3 || wn !== 1 || !st || !ro) begin
         errors++;
         $display("[TB] FAIL sb_timing: got resp T+%0d write T+%0d count %0d stable %0b ready %0b, expected T+4 T+3 1 1 1", rc, wc, wn, st, ro);
      end
      mem1[10'h008] = 32'h11223344;
      wr_q.push_back('{10'h008, 32'hBEEF3344});
      resp_q.push_back('{1'b0, 32'h0});
      applyStimulus(0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 4 || wc !== 3 || wn !== 1 || !st) begin
         errors++;
         $display("[TB] FAIL sh_timing: got resp T+%0d write T+%0d count %0d stable %0b, expected T+4 T+3 1 1", rc, wc, wn, st);
      end
   endtask

   task automatic test_word_store_mmio();
      int rc, wc, wn; bit st, ro;
      wr_q.push_back('{10'h3FF, 32'hDEADBEEF});
      resp_q.push_back('{1'b0, 32'h0});
      applyStimulus(0, 1'b1, 3'b010, 32'h0FFC, 32'hDEADBEEF, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 2 || wc !== 1 || wn !== 1 || !st) begin
         errors++;
         $display("[TB] FAIL sw_timing: got resp T+%0d write T+%0d count %0d stable %0b, expected T+2 T+1 1 1", rc, wc, wn, st);
      end
      resp_q.push_back('{1'b0, 32'hFFFFFFEF});
      applyStimulus(0, 1'b0, 3'b000, 32'h0FFC, 32'h0, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 3 || wn !== 0) begin
         errors++;
         $display("[TB] FAIL mmio_load: got resp T+%0d writes %0d, expected T+3 0", rc, wn);
      end
      resp_q.push_back('{1'b1, 32'h0});
      applyStimulus(0, 1'b1, 3'b000, 32'h0FFC, 32'h000000AA, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 1 || wn !== 0) begin
         errors++;
         $display("[TB] FAIL mmio_sb_reject: got resp T+%0d writes %0d, expected T+1 0", rc, wn);
      end
      resp_q.push_back('{1'b1, 32'h0});
      applyStimulus(0, 1'b1, 3'b001, 32'h0FA0, 32'h00001234, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 1 || wn !== 0) begin
         errors++;
         $display("[TB] FAIL mmio_base_sh_reject: got resp T+%0d writes %0d, expected T+1 0", rc, wn);
      end
      // Last word below the MMIO window still takes sub-word stores.
      mem1[10'h3E7] = 32'h0;
      wr_q.push_back('{10'h3E7, 32'h5A000000});
      resp_q.push_back('{1'b0, 32'h0});
      applyStimulus(0, 1'b1, 3'b000, 32'h0F9F, 32'h0000005A, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 4 || wc !== 3 || wn !== 1) begin
         errors++;
         $display("[TB] FAIL below_mmio_sb: got resp T+%0d write T+%0d count %0d, expected T+4 T+3 1", rc, wc, wn);
      end
   endtask

   task automatic test_errors();
      logic        wes  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s  [7] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b101, 3'b110};
      logic [31:0] adrs [7] = '{32'h06, 32'h03, 32'h00, 32'h1000, 32'h00, 32'h11, 32'h04};
      int rc, wc, wn; bit st, ro;
      for (int i = 0; i < 7; i++) begin
         resp_q.push_back('{1'b1, 32'h0});
         applyStimulus(0, wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rc, wc, wn, st, ro);
         checks++;
         if (rc !== 1 || wn !== 0 || !ro) begin
            errors++;
            $display("[TB] FAIL reject %0d: got resp T+%0d writes %0d ready %0b, expected T+1 0 1", i, rc, wn, ro);
         end
      end
   endtask

   task automatic test_latency3();
      int rc, wc, wn; bit st, ro;
      resp_q.push_back('{1'b0, 32'h8899AABB});
      applyStimulus(1, 1'b0, 3'b010, 32'h10, 32'h0, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 5 || wn !== 0 || !st || !ro) begin
         errors++;
         $display("[TB] FAIL l3_lw_timing: got resp T+%0d writes %0d stable %0b ready %0b, expected T+5 0 1 1", rc, wn, st, ro);
      end
      wr_q.push_back('{10'h008, 32'h1122CC44});
      resp_q.push_back('{1'b0, 32'h0});
      applyStimulus(1, 1'b1, 3'b000, 32'h21, 32'h000000CC, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 6 || wc !== 5 || wn !== 1 || !st) begin
         errors++;
         $display("[TB] FAIL l3_sb_timing: got resp T+%0d write T+%0d count %0d stable %0b, expected T+6 T+5 1 1", rc, wc, wn, st);
      end
   endtask

   task automatic test_reset_mid_op();
      int rc, wc, wn; bit st, ro;
      mem1[10'h008] = 32'h11223344;
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b000; req_addr[0] = 32'h20; req_wdata[0] = 32'h77;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_op: got ready=%0b rv=%0b we=%0b, expected 1 0 0", req_ready[0], resp_valid[0], mem_we[0]);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (mem1[10'h008] !== 32'h11223344) begin
         errors++;
         $display("[TB] FAIL reset_mid_op_mem: got %h, expected 11223344", mem1[10'h008]);
      end
      resp_q.push_back('{1'b0, 32'h11223344});
      applyStimulus(0, 1'b0, 3'b010, 32'h20, 32'h0, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 3 || wn !== 0 || !ro) begin
         errors++;
         $display("[TB] FAIL after_reset_lw: got resp T+%0d writes %0d ready %0b, expected T+3 0 1", rc, wn, ro);
      end
   endtask

   task automatic test_back_to_back();
      int rc, wc, wn; bit st, ro;
      resp_q.push_back('{1'b0, 32'h8899AABB});
      resp_q.push_back('{1'b0, 32'h000000BB});
      applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, rc, wc, wn, st, ro);
      applyStimulus(0, 1'b0, 3'b100, 32'h10, 32'h0, rc, wc, wn, st, ro);
      checks++;
      if (rc !== 3 || !ro || !st) begin
         errors++;
         $display("[TB] FAIL back_to_back: got resp T+%0d ready %0b stable %0b, expected T+3 1 1", rc, ro, st);
      end
   endtask

   task automatic checkOutput();
      repeat (3) @(negedge clk);
      checks++;
      if (resp_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d responses and %0d writes outstanding, expected 0 0", resp_q.size(), wr_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem1[i] = 32'h0;
         mem3[i] = 32'h0;
      end
      mem1[10'h004] = 32'h8899AABB;
      mem1[10'h008] = 32'h11223344;
      mem3[10'h004] = 32'h8899AABB;
      mem3[10'h008] = 32'h11223344;
      test_reset();
      test_loads();
      test_sub_word_stores();
      test_word_store_mmio();
      test_errors();
      test_latency3();
      test_reset_mid_op();
      test_back_to_back();
      checkOutput();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
